// File: rtl/minilogix_loader.sv
// Serial configuration transmitter for the minilogix core: takes bytes over a
// valid/ready stream and shifts them MSB first onto the load_en/load_clk/load_dat wires.
module minilogix_loader #(
    parameter int CLK_DIV = 4,
    parameter int LENW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [LENW-1:0] i_nbytes,
    input  logic            i_abort,
    input  logic [7:0]      i_data,
    input  logic            i_valid,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_stall,
    output logic            o_load_en,
    output logic            o_load_clk,
    output logic            o_load_dat
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, WAIT, TAIL} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bitn, bitn_nxt;
    logic [LENW-1:0] nbytes, nbytes_nxt;
    logic [LENW-1:0] accepted, accepted_nxt;
    logic [LENW-1:0] loaded, loaded_nxt;
    logic            buf_full, buf_full_nxt;
    logic [7:0]      buf_data, buf_data_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            ready_nxt, busy_nxt, done_nxt, stall_nxt;
    logic            en_nxt, lclk_nxt, dat_nxt;
    logic            phase_end, hs, load;

    assign phase_end = (cnt == CNT_LAST);
    assign hs        = i_valid && o_ready;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bitn_nxt     = bitn;
        nbytes_nxt   = nbytes;
        accepted_nxt = accepted;
        loaded_nxt   = loaded;
        buf_full_nxt = buf_full;
        buf_data_nxt = buf_data;
        shift_nxt    = shift;
        done_nxt     = 1'b0;
        load         = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_nbytes != '0) begin
                        state_nxt    = SETUP;
                        nbytes_nxt   = i_nbytes;
                        accepted_nxt = '0;
                        loaded_nxt   = '0;
                        cnt_nxt      = '0;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (phase_end) begin
                    cnt_nxt = '0;
                    if (buf_full) begin
                        state_nxt = LOW;
                        load      = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            LOW: begin
                if (phase_end) begin
                    cnt_nxt   = '0;
                    state_nxt = HIGH;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HIGH: begin
                if (phase_end) begin
                    cnt_nxt = '0;
                    if (bitn != 3'd0) begin
                        state_nxt = LOW;
                        bitn_nxt  = bitn - 3'd1;
                        shift_nxt = {shift[6:0], 1'b0};
                    end else if (loaded == nbytes) begin
                        state_nxt = TAIL;
                    end else if (buf_full) begin
                        state_nxt = LOW;
                        load      = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT: begin
                if (buf_full) begin
                    state_nxt = LOW;
                    load      = 1'b1;
                end
            end
            TAIL: begin
                if (phase_end) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Buffer hand-off to the shift register starts a fresh byte at bit 7.
        if (load) begin
            shift_nxt    = buf_data;
            bitn_nxt     = 3'd7;
            loaded_nxt   = loaded + LENW'(1);
            buf_full_nxt = 1'b0;
        end
        if (hs) begin
            buf_full_nxt = 1'b1;
            buf_data_nxt = i_data;
            accepted_nxt = accepted + LENW'(1);
        end

        if (i_abort && state != IDLE) begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            buf_full_nxt = 1'b0;
            done_nxt     = 1'b0;
        end

        busy_nxt  = (state_nxt != IDLE);
        en_nxt    = busy_nxt;
        lclk_nxt  = (state_nxt == HIGH);
        stall_nxt = (state_nxt == WAIT);
        ready_nxt = busy_nxt && !buf_full_nxt && (accepted_nxt < nbytes_nxt);
        if (state_nxt == LOW || state_nxt == HIGH) begin
            dat_nxt = shift_nxt[7];
        end else if (state_nxt == IDLE || state_nxt == SETUP) begin
            dat_nxt = 1'b0;
        end else begin
            dat_nxt = o_load_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bitn       <= '0;
            nbytes     <= '0;
            accepted   <= '0;
            loaded     <= '0;
            buf_full   <= 1'b0;
            o_ready    <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_stall    <= 1'b0;
            o_load_en  <= 1'b0;
            o_load_clk <= 1'b0;
            o_load_dat <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bitn       <= bitn_nxt;
            nbytes     <= nbytes_nxt;
            accepted   <= accepted_nxt;
            loaded     <= loaded_nxt;
            buf_full   <= buf_full_nxt;
            o_ready    <= ready_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
            o_stall    <= stall_nxt;
            o_load_en  <= en_nxt;
            o_load_clk <= lclk_nxt;
            o_load_dat <= dat_nxt;
        end
    end

    // Data-only registers; their contents are qualified by buf_full / state.
    always_ff @(posedge clk) begin
        buf_data <= buf_data_nxt;
        shift    <= shift_nxt;
    end
endmodule

// File: tb/tb_minilogix_loader.sv
// Scoreboard bench for minilogix_loader: expected bits and frame-end events are
// queued by the stimulus and consumed by a negedge monitor.
module tb_minilogix_loader;
    localparam int CLK_DIV = 2;
    localparam int LENW    = 8;

    logic            clk = 1'b0;
    logic            rst, i_start, i_abort, i_valid;
    logic [LENW-1:0] i_nbytes;
    logic [7:0]      i_data;
    logic            o_ready, o_busy, o_done, o_stall;
    logic            o_load_en, o_load_clk, o_load_dat;

    minilogix_loader #(.CLK_DIV(CLK_DIV), .LENW(LENW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_nbytes(i_nbytes),
        .i_abort(i_abort), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_stall(o_stall),
        .o_load_en(o_load_en), .o_load_clk(o_load_clk), .o_load_dat(o_load_dat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int width;   // load_en high cycles excluding stall cycles
        bit done;
        int hs;
        bit stall;
    } ev_t;

    int   checks = 0;
    int   errors = 0;
    bit   bitq[$];
    ev_t  endq[$];
    int   hs_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst && i_valid && o_ready) hs_total <= hs_total + 1;
    end

    // Monitor
    initial begin
        logic prev_en, prev_clk, prev_dat;
        int   width, stall_cnt, hs_mark;
        bit   b;
        ev_t  e;
        prev_en = 0; prev_clk = 0; prev_dat = 0;
        width = 0; stall_cnt = 0; hs_mark = 0;
        forever begin
            @(negedge clk);
            if (o_load_en === 1'b1) width++;
            if (o_stall === 1'b1) begin
                stall_cnt++;
                chk("stall_lines", {30'd0, o_load_en, o_load_clk}, 32'd2);
            end
            if (o_load_clk === 1'b1 && o_load_en !== 1'b1) begin
                checks++; errors++;
                $display("FAIL clk_without_en: got load_clk=1 with load_en=0, expected load_clk=0");
            end
            if (o_done === 1'b1 && o_load_en === 1'b1) begin
                checks++; errors++;
                $display("FAIL done_while_en: got done=1 with load_en=1, expected done only after en drops");
            end
            if (o_load_clk && prev_clk) chk("dat_stable_high", o_load_dat, prev_dat);
            if (o_load_clk && !prev_clk) begin
                if (bitq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_edge: got load_clk rise, expected none");
                end else begin
                    b = bitq.pop_front();
                    chk("dat_at_rise", o_load_dat, b);
                end
            end
            if ((prev_en && !o_load_en) || (o_done && !o_load_en && !prev_en)) begin
                if (endq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_end: got frame end, expected none");
                end else begin
                    e = endq.pop_front();
                    chk("frame_done", o_done, e.done);
                    if (e.width >= 0) chk("frame_width", width, e.width + stall_cnt);
                    chk("frame_hs", hs_total - hs_mark, e.hs);
                    chk("frame_stall_seen", (stall_cnt > 0), e.stall);
                    chk("end_lines", {28'd0, o_busy, o_load_clk, o_load_dat, o_stall}, 32'd0);
                end
                width = 0; stall_cnt = 0; hs_mark = hs_total;
            end
            prev_en = o_load_en; prev_clk = o_load_clk; prev_dat = o_load_dat;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "timeout");
    end

    task automatic expect_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bitq.push_back(v[i]);
    endtask

    task automatic expect_end(input int w, input bit d, input int h, input bit s);
        ev_t e;
        e.width = w; e.done = d; e.hs = h; e.stall = s;
        endq.push_back(e);
    endtask

    task automatic start_frame(input int n);
        i_start = 1'b1; i_nbytes = LENW'(n);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] v);
        int i;
        i_data = v; i_valid = 1'b1;
        for (i = 0; i < 2000; i++) begin
            if (o_ready) break;
            @(negedge clk);
        end
        if (i == 2000) begin
            checks++; errors++;
            $display("FAIL push_timeout: got no o_ready, expected handshake");
        end else begin
            @(negedge clk);
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_rises(input int k);
        int   c, i;
        logic p;
        c = 0; p = o_load_clk;
        for (i = 0; i < 2000 && c < k; i++) begin
            @(negedge clk);
            if (o_load_clk && !p) c++;
            p = o_load_clk;
        end
        if (c < k) begin
            checks++; errors++;
            $display("FAIL rise_timeout: got %0d rises, expected %0d", c, k);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (endq.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("drain_events", endq.size(), 0);
        chk("drain_bits", bitq.size(), 0);
    endtask

    initial begin
        rst = 1'b1; i_start = 0; i_abort = 0; i_valid = 0; i_nbytes = '0; i_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {25'd0, o_ready, o_busy, o_done, o_stall, o_load_en, o_load_clk, o_load_dat}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5 presented together with start.
        expect_byte(8'hA5);
        expect_end(36, 1, 1, 0);
        i_data = 8'hA5; i_valid = 1'b1;
        start_frame(1);
        chk("busy_after_start", {30'd0, o_busy, o_load_en}, 32'd3);
        push_byte(8'hA5);
        wait_drain();

        // Three bytes streamed back to back.
        expect_byte(8'h01); expect_byte(8'hFF); expect_byte(8'h3C);
        expect_end(100, 1, 3, 0);
        start_frame(3);
        push_byte(8'h01); push_byte(8'hFF); push_byte(8'h3C);
        wait_drain();

        // Second byte withheld long enough to stall the shifter.
        expect_byte(8'h81); expect_byte(8'h7E);
        expect_end(68, 1, 2, 1);
        start_frame(2);
        push_byte(8'h81);
        repeat (50) @(negedge clk);
        push_byte(8'h7E);
        wait_drain();

        // Abort during the HIGH phase of the fifth bit, then a clean frame.
        bitq.push_back(1); bitq.push_back(1); bitq.push_back(0);
        bitq.push_back(0); bitq.push_back(0);
        expect_end(21, 0, 1, 0);
        start_frame(1);
        push_byte(8'hC3);
        wait_rises(5);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_lines", {28'd0, o_busy, o_load_en, o_load_clk, o_load_dat}, 32'd0);
        wait_drain();
        expect_byte(8'h5A);
        expect_end(36, 1, 1, 0);
        start_frame(1);
        push_byte(8'h5A);
        wait_drain();

        // Zero-length frame.
        expect_end(0, 1, 0, 0);
        start_frame(0);
        chk("zero_len_lines", {29'd0, o_ready, o_load_en, o_done}, 32'd1);
        @(negedge clk);
        chk("zero_len_done_once", o_done, 1'b0);
        wait_drain();

        // Start pulsed while busy is ignored; reset lands in TAIL.
        expect_byte(8'h96);
        expect_end(35, 0, 1, 0);
        start_frame(1);
        push_byte(8'h96);
        wait_rises(3);
        start_frame(3);
        wait_rises(5);
        @(negedge clk);
        @(negedge clk);
        chk("in_tail", {30'd0, o_load_en, o_load_clk}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {25'd0, o_ready, o_busy, o_done, o_stall, o_load_en, o_load_clk, o_load_dat}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_idle", {30'd0, o_busy, o_load_en}, 32'd0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
